// File: rtl/ctrl_hazard_pipe.sv
// rtl/ctrl_hazard_pipe.sv - E/M/W control staging, E-stage redirect and hazard unit for the 5-stage RV32I pipe
module ctrl_hazard_pipe #(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWriteD,
  input  logic [1:0]        resultSrcD,
  input  logic              memWriteD,
  input  logic [1:0]        jumpD,
  input  logic [2:0]        branchD,
  input  logic              ALUSrcD,
  input  logic              luiD,
  input  logic [ALUC_W-1:0] aluCtrlD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              zeroE,
  input  logic              ltE,
  output logic              regWriteE,
  output logic              memWriteE,
  output logic              ALUSrcE,
  output logic              luiE,
  output logic [1:0]        resultSrcE,
  output logic [1:0]        jumpE,
  output logic [2:0]        branchE,
  output logic [ALUC_W-1:0] aluCtrlE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              regWriteM,
  output logic              memWriteM,
  output logic              luiM,
  output logic [1:0]        resultSrcM,
  output logic [REG_AW-1:0] RdM,
  output logic              regWriteW,
  output logic [1:0]        resultSrcW,
  output logic [REG_AW-1:0] RdW,
  output logic [1:0]        pcSrcE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE
);

  logic taken;
  logic lw_stall;
  logic redirect;

  // E never holds: a load-use stall or a redirect turns the slot into a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flushE) begin
      regWriteE  <= 1'b0;
      resultSrcE <= 2'b00;
      memWriteE  <= 1'b0;
      jumpE      <= 2'b00;
      branchE    <= 3'b000;
      ALUSrcE    <= 1'b0;
      luiE       <= 1'b0;
      aluCtrlE   <= '0;
      Rs1E       <= '0;
      Rs2E       <= '0;
      RdE        <= '0;
    end else begin
      regWriteE  <= regWriteD;
      resultSrcE <= resultSrcD;
      memWriteE  <= memWriteD;
      jumpE      <= jumpD;
      branchE    <= branchD;
      ALUSrcE    <= ALUSrcD;
      luiE       <= luiD;
      aluCtrlE   <= aluCtrlD;
      Rs1E       <= Rs1D;
      Rs2E       <= Rs2D;
      RdE        <= RdD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteM  <= 1'b0;
      resultSrcM <= 2'b00;
      memWriteM  <= 1'b0;
      luiM       <= 1'b0;
      RdM        <= '0;
      regWriteW  <= 1'b0;
      resultSrcW <= 2'b00;
      RdW        <= '0;
    end else begin
      regWriteM  <= regWriteE;
      resultSrcM <= resultSrcE;
      memWriteM  <= memWriteE;
      luiM       <= luiE;
      RdM        <= RdE;
      regWriteW  <= regWriteM;
      resultSrcW <= resultSrcM;
      RdW        <= RdM;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (branchE)
      3'b001:  taken = zeroE;
      3'b010:  taken = ~zeroE;
      3'b011:  taken = ltE;
      3'b100:  taken = ~ltE;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pcSrcE = 2'b00;
    if (jumpE == 2'b10)
      pcSrcE = 2'b10;
    else if (jumpE == 2'b01 || taken)
      pcSrcE = 2'b01;
  end

  assign lw_stall = (resultSrcE == 2'b01) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign redirect = (pcSrcE != 2'b00);

  assign stallF = lw_stall;
  assign stallD = lw_stall;
  assign flushD = redirect;
  assign flushE = lw_stall | redirect;

  // M is the younger producer, so it wins over W; x0 is never a forwarding source
  always_comb begin
    forwardAE = 2'b00;
    if (regWriteM && (RdM != '0) && (RdM == Rs1E))
      forwardAE = 2'b10;
    else if (regWriteW && (RdW != '0) && (RdW == Rs1E))
      forwardAE = 2'b01;
  end

  always_comb begin
    forwardBE = 2'b00;
    if (regWriteM && (RdM != '0) && (RdM == Rs2E))
      forwardBE = 2'b10;
    else if (regWriteW && (RdW != '0) && (RdW == Rs2E))
      forwardBE = 2'b01;
  end

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// tb/tb_ctrl_hazard_pipe.sv - directed self-checking bench for ctrl_hazard_pipe
module tb_ctrl_hazard_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       regWriteD, memWriteD, ALUSrcD, luiD;
  logic [1:0] resultSrcD, jumpD;
  logic [2:0] branchD, aluCtrlD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       zeroE, ltE;
  logic       regWriteE, memWriteE, ALUSrcE, luiE;
  logic [1:0] resultSrcE, jumpE;
  logic [2:0] branchE, aluCtrlE;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic       regWriteM, memWriteM, luiM;
  logic [1:0] resultSrcM;
  logic [4:0] RdM;
  logic       regWriteW;
  logic [1:0] resultSrcW;
  logic [4:0] RdW;
  logic [1:0] pcSrcE;
  logic       stallF, stallD, flushD, flushE;
  logic [1:0] forwardAE, forwardBE;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_hazard_pipe #(.REG_AW(5), .ALUC_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .regWriteD(regWriteD), .resultSrcD(resultSrcD), .memWriteD(memWriteD),
    .jumpD(jumpD), .branchD(branchD), .ALUSrcD(ALUSrcD), .luiD(luiD),
    .aluCtrlD(aluCtrlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .zeroE(zeroE), .ltE(ltE),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .ALUSrcE(ALUSrcE), .luiE(luiE),
    .resultSrcE(resultSrcE), .jumpE(jumpE), .branchE(branchE), .aluCtrlE(aluCtrlE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .luiM(luiM),
    .resultSrcM(resultSrcM), .RdM(RdM),
    .regWriteW(regWriteW), .resultSrcW(resultSrcW), .RdW(RdW),
    .pcSrcE(pcSrcE), .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [1:0] j, input logic [2:0] br,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    regWriteD  = rw;
    resultSrcD = rs;
    memWriteD  = mw;
    jumpD      = j;
    branchD    = br;
    Rs1D       = r1;
    Rs2D       = r2;
    RdD        = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    zeroE = 1'b0;
    ltE = 1'b0;
    ALUSrcD = 1'b0;
    luiD = 1'b0;
    aluCtrlD = 3'b000;
    drive_d(1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0);
    repeat (2) tick();

    chk("rst_regWriteE", 8'(regWriteE), 8'h0);
    chk("rst_RdE", 8'(RdE), 8'h0);
    chk("rst_regWriteM", 8'(regWriteM), 8'h0);
    chk("rst_RdW", 8'(RdW), 8'h0);
    chk("rst_pcSrcE", 8'(pcSrcE), 8'h0);
    chk("rst_stallF", 8'(stallF), 8'h0);
    chk("rst_flushE", 8'(flushE), 8'h0);
    chk("rst_forwardAE", 8'(forwardAE), 8'h0);
    rst_n = 1'b1;

    // fill the pipe with regWrite ops, then reset between edges
    drive_d(1'b1, 2'b00, 1'b1, 2'b00, 3'b000, 5'd1, 5'd2, 5'd7);
    luiD = 1'b1;
    repeat (3) tick();
    chk("fill_regWriteW", 8'(regWriteW), 8'h1);
    chk("fill_RdW", 8'(RdW), 8'h7);
    chk("fill_memWriteM", 8'(memWriteM), 8'h1);
    chk("fill_luiM", 8'(luiM), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_regWriteE", 8'(regWriteE), 8'h0);
    chk("midrst_regWriteM", 8'(regWriteM), 8'h0);
    chk("midrst_regWriteW", 8'(regWriteW), 8'h0);
    chk("midrst_memWriteM", 8'(memWriteM), 8'h0);
    chk("midrst_RdM", 8'(RdM), 8'h0);
    chk("midrst_pcSrcE", 8'(pcSrcE), 8'h0);
    rst_n = 1'b1;
    luiD = 1'b0;

    // add x3,x1,x2 ; sub x4,x3,x1 ; or x6,x3,x5
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd1, 5'd2, 5'd3);
    tick();
    chk("add_regWriteE", 8'(regWriteE), 8'h1);
    chk("add_RdE", 8'(RdE), 8'h3);
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd3, 5'd1, 5'd4);
    aluCtrlD = 3'b001;
    tick();
    chk("sub_forwardAE_M", 8'(forwardAE), 8'h2);
    chk("sub_forwardBE", 8'(forwardBE), 8'h0);
    chk("sub_aluCtrlE", 8'(aluCtrlE), 8'h1);
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd3, 5'd5, 5'd6);
    aluCtrlD = 3'b000;
    tick();
    chk("or_forwardAE_W", 8'(forwardAE), 8'h1);
    chk("or_forwardBE", 8'(forwardBE), 8'h0);

    // two writers of x3 back to back: M must win over W
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd1, 5'd2, 5'd3);
    tick();
    tick();
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd3, 5'd3, 5'd10);
    tick();
    chk("prio_forwardAE", 8'(forwardAE), 8'h2);
    chk("prio_forwardBE", 8'(forwardBE), 8'h2);

    // lw x5 ; add x6,x1,x5
    drive_d(1'b1, 2'b01, 1'b0, 2'b00, 3'b000, 5'd1, 5'd0, 5'd5);
    ALUSrcD = 1'b1;
    tick();
    chk("lw_ALUSrcE", 8'(ALUSrcE), 8'h1);
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd1, 5'd5, 5'd6);
    ALUSrcD = 1'b0;
    #1;
    chk("lu_stallF", 8'(stallF), 8'h1);
    chk("lu_stallD", 8'(stallD), 8'h1);
    chk("lu_flushE", 8'(flushE), 8'h1);
    chk("lu_flushD", 8'(flushD), 8'h0);
    tick();
    chk("lu_bubble_regWriteE", 8'(regWriteE), 8'h0);
    chk("lu_bubble_RdE", 8'(RdE), 8'h0);
    chk("lu_RdM", 8'(RdM), 8'h5);
    chk("lu_bubble_forwardBE", 8'(forwardBE), 8'h0);
    chk("lu_release_stallF", 8'(stallF), 8'h0);
    tick();
    chk("lu_forwardBE_W", 8'(forwardBE), 8'h1);
    chk("lu_resultSrcW", 8'(resultSrcW), 8'h1);

    // branches
    drive_d(1'b0, 2'b00, 1'b0, 2'b00, 3'b001, 5'd1, 5'd2, 5'd0);
    tick();
    zeroE = 1'b1;
    #1;
    chk("beq_pcSrcE", 8'(pcSrcE), 8'h1);
    chk("beq_flushD", 8'(flushD), 8'h1);
    chk("beq_flushE", 8'(flushE), 8'h1);
    chk("beq_stallF", 8'(stallF), 8'h0);
    zeroE = 1'b0;
    drive_d(1'b0, 2'b00, 1'b0, 2'b00, 3'b100, 5'd1, 5'd2, 5'd0);
    #1;
    chk("beq_nt_pcSrcE", 8'(pcSrcE), 8'h0);
    tick();
    ltE = 1'b1;
    #1;
    chk("bge_nt_pcSrcE", 8'(pcSrcE), 8'h0);
    chk("bge_nt_flushE", 8'(flushE), 8'h0);
    ltE = 1'b0;
    #1;
    chk("bge_t_pcSrcE", 8'(pcSrcE), 8'h1);
    ltE = 1'b1;
    drive_d(1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 5'd1, 5'd2, 5'd0);
    tick();
    zeroE = 1'b0;
    #1;
    chk("bne_pcSrcE", 8'(pcSrcE), 8'h1);
    zeroE = 1'b1;
    drive_d(1'b0, 2'b00, 1'b0, 2'b00, 3'b101, 5'd1, 5'd2, 5'd0);
    tick();
    zeroE = 1'b0;
    ltE = 1'b0;
    #1;
    chk("br101_pcSrcE", 8'(pcSrcE), 8'h0);
    drive_d(1'b0, 2'b00, 1'b0, 2'b00, 3'b011, 5'd1, 5'd2, 5'd0);
    tick();
    ltE = 1'b1;
    #1;
    chk("blt_pcSrcE", 8'(pcSrcE), 8'h1);
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd1, 5'd2, 5'd9);
    tick();
    chk("br_bubble_regWriteE", 8'(regWriteE), 8'h0);
    chk("br_bubble_branchE", 8'(branchE), 8'h0);
    ltE = 1'b0;

    // jalr in E that also matches a load-use in D
    drive_d(1'b1, 2'b01, 1'b0, 2'b10, 3'b000, 5'd1, 5'd0, 5'd8);
    tick();
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd8, 5'd2, 5'd11);
    #1;
    chk("jalr_pcSrcE", 8'(pcSrcE), 8'h2);
    chk("jalr_stallF", 8'(stallF), 8'h1);
    chk("jalr_stallD", 8'(stallD), 8'h1);
    chk("jalr_flushD", 8'(flushD), 8'h1);
    chk("jalr_flushE", 8'(flushE), 8'h1);
    tick();
    chk("jalr_bubble_jumpE", 8'(jumpE), 8'h0);
    chk("jalr_bubble_regWriteE", 8'(regWriteE), 8'h0);

    // x0 is never forwarded and never stalls
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd1, 5'd2, 5'd0);
    tick();
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd12);
    tick();
    chk("x0_regWriteM", 8'(regWriteM), 8'h1);
    chk("x0_forwardAE", 8'(forwardAE), 8'h0);
    chk("x0_forwardBE", 8'(forwardBE), 8'h0);
    drive_d(1'b1, 2'b01, 1'b0, 2'b00, 3'b000, 5'd1, 5'd0, 5'd0);
    tick();
    drive_d(1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd13);
    #1;
    chk("x0_lw_resultSrcE", 8'(resultSrcE), 8'h1);
    chk("x0_stallF", 8'(stallF), 8'h0);
    chk("x0_flushE", 8'(flushE), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_hazard_pipe.md
Name: ctrl_hazard_pipe

Overview:
- Downstream neighbour of the main decoder in the 5-stage RV32I pipeline.
- Registers the decoder's D-stage control bundle through the E, M and W stages.
- Resolves branch/jump redirection in E.
- Generates the hazard signals: load-use stall, control-flush and operand forwarding selects.
- The datapath consumes the staged controls; F/D registers consume the stall/flush outputs.

Parameters:
- REG_AW, 5, register-address width.
- ALUC_W, 3, width of the ALU control word produced by the ALU decoder in D.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- regWriteD  in  1  decoder control.
- resultSrcD  in  2  00 ALU, 01 mem, 10 PC+4, 11 imm.
- memWriteD  in  1  decoder control.
- jumpD  in  2  00 none, 01 jal, 10 jalr.
- branchD  in  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge.
- ALUSrcD  in  1  decoder control.
- luiD  in  1  decoder control.
- aluCtrlD  in  ALUC_W  ALU operation.
- Rs1D, Rs2D, RdD  in  REG_AW  D-stage register fields.
- zeroE  in  1  ALU result==0.
- ltE  in  1  signed rs1<rs2 from the E-stage ALU.
- regWriteE, memWriteE, ALUSrcE, luiE  out  1  E-stage controls.
- resultSrcE  out  2  E-stage control.
- jumpE  out  2  E-stage control.
- branchE  out  3  E-stage control.
- aluCtrlE  out  ALUC_W  E-stage ALU operation.
- Rs1E, Rs2E, RdE  out  REG_AW  E-stage register fields.
- regWriteM, memWriteM, luiM  out  1  M-stage controls.
- resultSrcM  out  2  M-stage control.
- RdM  out  REG_AW  M-stage destination.
- regWriteW  out  1  W-stage control.
- resultSrcW  out  2  W-stage control.
- RdW  out  REG_AW  W-stage destination.
- pcSrcE  out  2  00 PC+4, 01 PC+imm (taken branch / jal), 10 ALU result (jalr).
- stallF, stallD  out  1  hold the PC and IF/ID registers.
- flushD  out  1  clear the IF/ID register.
- flushE  out  1  internal bubble indicator, exported for observation.
- forwardAE, forwardBE  out  2  00 register file, 10 ALU result in M, 01 result in W.

Behaviour:
- Reset (rst_n low, asynchronous): every E/M/W register clears to 0, which reads as NOP with Rd=x0.
  - Combinational outputs then evaluate from zeroed state: pcSrcE=00, stalls/flushes=0, forwards=00.
  - Reset mid-operation discards all in-flight controls immediately; no write enables survive.
- ID/EX register (posedge):
  - flushE=1: load all-zero (bubble: regWrite=0, memWrite=0, jump=0, branch=0, Rd/Rs=0).
  - Otherwise: capture all D inputs.
  - The E register never holds; a stall bubbles E instead.
- EX/MEM and MEM/WB registers: capture unconditionally every cycle; no stall or flush.
  - M captures regWrite, resultSrc, memWrite, lui, Rd from E.
  - W captures regWrite, resultSrc, Rd from M.
- Branch condition (combinational):
  - taken = (branchE==001 & zeroE) | (branchE==010 & ~zeroE) | (branchE==011 & ltE) | (branchE==100 & ~ltE).
  - Any other branchE value gives taken=0.
- pcSrcE:
  - 10 if jumpE==10.
  - Else 01 if jumpE==01 or taken.
  - Else 00.
- Load-use detection: lwStall = (resultSrcE==01) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
- Hazard outputs:
  - stallF = stallD = lwStall.
  - flushD = (pcSrcE!=00).
  - flushE = lwStall | (pcSrcE!=00).
  - Simultaneous load-use and redirect: all four assert. The flushD/flushE clearing wins in the downstream registers, and the stall is harmless.
- Forwarding, per operand (Rs1E → forwardAE, Rs2E → forwardBE):
  - 10 if regWriteM & RdM!=0 & RdM==RsxE.
  - Else 01 if regWriteW & RdW!=0 & RdW==RsxE.
  - Else 00.
  - M has priority over W when both match.
  - x0 is never forwarded.
- Latency:
  - Controls appear in E one cycle after D, in M after two, in W after three.
  - A bubble inserted by flushE reaches W three cycles later.

Test Plan:
- Reset mid-stream: pipeline full of regWrite=1 ops, pulse rst_n low between edges → all staged outputs 0 immediately; pcSrcE=00.
- Straight-line R-type `add x3,x1,x2` then `sub x4,x3,x1` in D → after one edge forwardAE=10; after the next edge (x3 now in W) forwardAE=01; forwardBE=00.
- Load-use: `lw x5` in E (resultSrcE=01, RdE=5), D has Rs2D=5 → stallF=stallD=flushE=1, flushD=0. Next cycle: E holds a bubble (regWriteE=0), M holds the lw, forwardBE=00 until lw reaches W, then 01.
- Branches: branchE=001 with zeroE=1 → pcSrcE=01, flushD=flushE=1; branchE=100 with ltE=1 → pcSrcE=00, no flush; branchE=010 with zeroE=0 → pcSrcE=01.
- jalr: jumpE=10 plus a simultaneous load-use match in D → pcSrcE=10; stallF, stallD, flushD and flushE all 1; E next cycle is a bubble.
- x0 guard: RdM=0 with regWriteM=1 and Rs1E=0 → forwardAE=00; lw to x0 followed by a use of x0 → no stall.
